// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM fade controller.
// Optional done pulse is enabled by defining PWM_FADE_DONE_EN.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  localparam logic [31:0] PWM_RST_MAX = '1;

  typedef enum logic {
    PWM_FADE_IDLE,
    PWM_FADE_RAMP
  } pwm_fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Fade command handshake between requester and pwm_fade_ctrl.
// The requester holds a command until cmd_ready is seen high.
interface pwm_fade_ctrl_if
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int DIV_WIDTH = 8
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_target;
  logic [WIDTH-1:0]     cmd_step;
  logic [DIV_WIDTH-1:0] cmd_div;
  logic [WIDTH-1:0]     cmd_max;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_div,
    output cmd_max,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_div,
    input  cmd_max,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_period_counter.sv
// Mirror of the PWM generator's period counter.
// o_boundary is high in the cycle whose rising edge wraps cnt to 0.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_max,
  output logic             o_boundary,
  output logic             o_period_start
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_period_start;

  assign o_boundary     = (r_cnt == i_max);
  assign o_period_start = r_period_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= o_boundary ? '0 : r_cnt + WIDTH'(1);
      r_period_start <= o_boundary;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer driving duty/max_value of the PWM generator.
// Define PWM_FADE_DONE_EN to add the one-cycle done pulse output.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH,
  parameter int DIV_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  pwm_fade_ctrl_if.slave   cmd,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] max_value,
  output logic             period_start,
`ifdef PWM_FADE_DONE_EN
  output logic             done,
`endif
  output logic             busy
);

  pwm_fade_state_t r_state;
  pwm_fade_state_t w_state_nxt;

  logic [WIDTH-1:0]     r_duty;
  logic [WIDTH-1:0]     r_max;
  logic [WIDTH-1:0]     r_p_target;
  logic [WIDTH-1:0]     r_p_step;
  logic [WIDTH-1:0]     r_p_max;
  logic [DIV_WIDTH-1:0] r_p_div;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_ready;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_duty_nxt;
  logic [WIDTH-1:0]     w_max_nxt;
  logic [DIV_WIDTH-1:0] w_div_cnt_nxt;
  logic [WIDTH-1:0]     w_step_in;
  logic [WIDTH-1:0]     w_gap;
  logic [WIDTH-1:0]     w_delta;
  logic [WIDTH-1:0]     w_stepped;
  logic                 w_up;
  logic                 w_accept;
  logic                 w_boundary;
  logic                 w_fin;

  pwm_period_counter #(
    .WIDTH(WIDTH)
  ) u_period (
    .clk           (clk),
    .rst           (rst),
    .i_max         (r_max),
    .o_boundary    (w_boundary),
    .o_period_start(period_start)
  );

  assign w_accept  = cmd.cmd_valid && r_ready;
  assign w_step_in = (cmd.cmd_step == '0) ? WIDTH'(1)
                                          : cmd.cmd_step;

  // Step is clamped to the remaining gap, so no overshoot or wrap.
  assign w_up      = r_p_target > r_duty;
  assign w_gap     = w_up ? r_p_target - r_duty
                          : r_duty - r_p_target;
  assign w_delta   = (r_p_step < w_gap) ? r_p_step : w_gap;
  assign w_stepped = w_up ? r_duty + w_delta
                          : r_duty - w_delta;

  always_comb begin
    w_state_nxt   = r_state;
    w_duty_nxt    = r_duty;
    w_max_nxt     = r_max;
    w_div_cnt_nxt = r_div_cnt;
    w_fin         = 1'b0;
    unique case (r_state)
      PWM_FADE_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = PWM_FADE_RAMP;
          w_div_cnt_nxt = '0;
        end
      end
      PWM_FADE_RAMP: begin
        if (w_boundary) begin
          w_max_nxt = r_p_max;
          if (r_div_cnt == r_p_div) begin
            w_duty_nxt    = w_stepped;
            w_div_cnt_nxt = '0;
          end else begin
            w_div_cnt_nxt = r_div_cnt + DIV_WIDTH'(1);
          end
          if (w_duty_nxt == r_p_target) begin
            w_fin       = 1'b1;
            w_state_nxt = PWM_FADE_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = PWM_FADE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PWM_FADE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty     <= '0;
      r_max      <= WIDTH'(PWM_RST_MAX);
      r_div_cnt  <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_p_target <= '0;
      r_p_step   <= WIDTH'(1);
      r_p_div    <= '0;
      r_p_max    <= WIDTH'(PWM_RST_MAX);
    end else begin
      r_duty    <= w_duty_nxt;
      r_max     <= w_max_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_ready   <= (w_state_nxt == PWM_FADE_IDLE);
      r_busy    <= (w_state_nxt == PWM_FADE_RAMP);
      if (w_accept) begin
        r_p_target <= cmd.cmd_target;
        r_p_step   <= w_step_in;
        r_p_div    <= cmd.cmd_div;
        r_p_max    <= cmd.cmd_max;
      end
    end
  end

`ifdef PWM_FADE_DONE_EN
  logic r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
    end
  end

  assign done = r_done;
`else
  logic w_fin_unused;
  assign w_fin_unused = w_fin;
`endif

  assign cmd.cmd_ready = r_ready;
  assign duty          = r_duty;
  assign max_value     = r_max;
  assign busy          = r_busy;

endmodule
